// File: rtl/piccolo_key_sched_seq.sv
// Sequential Piccolo-80 key schedule: whitening keys plus one round-key pair per beat.
// Optional `PICCOLO_RK_BUFFER_EN adds an 800-bit buffer of all round keys.
module piccolo_key_sched_seq (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [79:0]  key,
    output logic [63:0]  wk,
    output logic         wk_valid,
    output logic [31:0]  rk_pair,
    output logic [4:0]   rk_round,
    output logic         rk_last,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         busy
`ifdef PICCOLO_RK_BUFFER_EN
    ,
    output logic [799:0] rk_all,
    output logic         rk_all_valid
`endif
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [15:0] k0, k1, k2, k3, k4;
    logic [4:0]  i;
    logic [2:0]  m5;
    logic [4:0]  c;
    logic [31:0] con;
    logic [31:0] sel;
    logic        cap;
    logic        beat;
    logic        done;

    assign busy      = (state == RUN);
    assign key_ready = ~busy;
    assign rk_valid  = busy;
    assign rk_round  = i;
    assign rk_last   = busy & (i == 5'd24);

    assign cap  = ~busy & key_valid;
    assign beat = busy & rk_ready;
    assign done = beat & (i == 5'd24);

    assign c   = i + 5'd1;
    assign con = {c, 5'b0, c, 2'b00, c, 5'b0, c} ^ 32'h0f1e2d3c;

    always_comb begin
        sel = '0;
        case (m5)
            3'd0, 3'd2: sel = {k2, k3};
            3'd1, 3'd4: sel = {k0, k1};
            3'd3:       sel = {k4, k4};
            default:    sel = '0;
        endcase
    end

    // Gated to zero outside RUN so the idle bus is quiet and matches reset.
    assign rk_pair = busy ? (sel ^ con) : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            k0       <= '0;
            k1       <= '0;
            k2       <= '0;
            k3       <= '0;
            k4       <= '0;
            i        <= '0;
            m5       <= '0;
            wk       <= '0;
            wk_valid <= 1'b0;
        end else if (cap) begin
            state    <= RUN;
            k0       <= key[79:64];
            k1       <= key[63:48];
            k2       <= key[47:32];
            k3       <= key[31:16];
            k4       <= key[15:0];
            i        <= '0;
            m5       <= '0;
            wk       <= {key[79:72], key[55:48],
                         key[63:56], key[71:64],
                         key[15:8],  key[23:16],
                         key[31:24], key[7:0]};
            wk_valid <= 1'b1;
        end else if (done) begin
            state <= IDLE;
            i     <= '0;
            m5    <= '0;
        end else if (beat) begin
            i  <= i + 5'd1;
            m5 <= (m5 == 3'd4) ? 3'd0 : m5 + 3'd1;
        end
    end

`ifdef PICCOLO_RK_BUFFER_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rk_all       <= '0;
            rk_all_valid <= 1'b0;
        end else if (cap) begin
            rk_all_valid <= 1'b0;
        end else if (beat) begin
            rk_all[10'd799 - {i, 5'b0} -: 32] <= rk_pair;
            if (done)
                rk_all_valid <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_piccolo_key_sched_seq.sv
// Directed self-checking bench for piccolo_key_sched_seq.
// Buffer checks compile in when PICCOLO_RK_BUFFER_EN is defined.
module tb_piccolo_key_sched_seq;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [79:0]  key;
    logic [63:0]  wk;
    logic         wk_valid;
    logic [31:0]  rk_pair;
    logic [4:0]   rk_round;
    logic         rk_last;
    logic         rk_valid;
    logic         rk_ready;
    logic         busy;
`ifdef PICCOLO_RK_BUFFER_EN
    logic [799:0] rk_all;
    logic         rk_all_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [79:0] K1 = 80'h00112233445566778899;
    localparam logic [79:0] K2 = 80'hffeeddccbbaa99887766;

    piccolo_key_sched_seq dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_valid(key_valid),
        .key_ready(key_ready),
        .key      (key),
        .wk       (wk),
        .wk_valid (wk_valid),
        .rk_pair  (rk_pair),
        .rk_round (rk_round),
        .rk_last  (rk_last),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .busy     (busy)
`ifdef PICCOLO_RK_BUFFER_EN
        ,
        .rk_all      (rk_all),
        .rk_all_valid(rk_all_valid)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] exp_wk(input logic [79:0] k);
        logic [15:0] a0, a1, a3, a4;
        a0 = k[79:64];
        a1 = k[63:48];
        a3 = k[31:16];
        a4 = k[15:0];
        return {a0[15:8], a1[7:0], a1[15:8], a0[7:0],
                a4[15:8], a3[7:0], a3[15:8], a4[7:0]};
    endfunction

    function automatic logic [31:0] exp_rk(input logic [79:0] k, input int r);
        logic [4:0]  cc;
        logic [31:0] cn;
        logic [31:0] s;
        cc = 5'(r + 1);
        cn = ({27'd0, cc} << 27) | ({27'd0, cc} << 17)
           | ({27'd0, cc} << 10) | {27'd0, cc};
        cn = cn ^ 32'h0f1e2d3c;
        case (r % 5)
            0, 2:    s = k[47:16];
            1, 4:    s = k[79:48];
            default: s = {k[15:0], k[15:0]};
        endcase
        return s ^ cn;
    endfunction

    // Offer a key at a negedge; it is captured at the following posedge.
    task automatic send_key(input logic [79:0] k);
        key       = k;
        key_valid = 1'b1;
        n_checks++;
        if (key_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: got %b expected 1", key_ready);
        end
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    // Drain a stream with rk_ready high, checking every beat.
    task automatic drain_full(input logic [79:0] k, input string tag);
        rk_ready = 1'b1;
        n_checks++;
        if (wk !== exp_wk(k) || wk_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_wk: got %h/%b expected %h/1", tag, wk, wk_valid, exp_wk(k));
        end
        for (int b = 0; b < 25; b++) begin
            n_checks++;
            if (rk_valid !== 1'b1 || rk_pair !== exp_rk(k, b) ||
                rk_round !== 5'(b) || rk_last !== (b == 24) || key_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_beat%0d: got v=%b pair=%h rnd=%0d last=%b kr=%b expected pair=%h",
                         tag, b, rk_valid, rk_pair, rk_round, rk_last, key_ready, exp_rk(k, b));
            end
            @(negedge clk);
        end
        n_checks++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_end: got kr=%b v=%b busy=%b expected 1 0 0",
                     tag, key_ready, rk_valid, busy);
        end
    endtask

    task automatic test_reset;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key       = '0;
        rk_ready  = 1'b0;
        #12;
        n_checks++;
        if (key_ready !== 1'b1 || wk !== 64'h0 || wk_valid !== 1'b0 ||
            rk_pair !== 32'h0 || rk_round !== 5'd0 || rk_last !== 1'b0 ||
            rk_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got kr=%b wk=%h wkv=%b pair=%h rnd=%0d last=%b v=%b busy=%b expected 1 0 0 0 0 0 0 0",
                     key_ready, wk, wk_valid, rk_pair, rk_round, rk_last, rk_valid, busy);
        end
`ifdef PICCOLO_RK_BUFFER_EN
        n_checks++;
        if (rk_all !== '0 || rk_all_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_buf: got valid=%b expected 0 and zero buffer", rk_all_valid);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors;
        send_key(K1);
        rk_ready = 1'b1;
        n_checks++;
        if (wk !== 64'h0033_2211_8877_6699) begin
            n_fail++;
            $display("FAIL vec_wk: got %h expected 0033221188776699", wk);
        end
        for (int b = 0; b < 25; b++) begin
            if (b == 0) begin
                n_checks++;
                if (rk_pair !== 32'h4349_4f4a) begin
                    n_fail++;
                    $display("FAIL vec_b0: got %h expected 43494f4a", rk_pair);
                end
            end
            if (b == 1) begin
                n_checks++;
                if (rk_pair !== 32'h1f0b_070d) begin
                    n_fail++;
                    $display("FAIL vec_b1: got %h expected 1f0b070d", rk_pair);
                end
            end
            if (b == 3) begin
                n_checks++;
                if (rk_pair !== 32'ha78f_b5a1) begin
                    n_fail++;
                    $display("FAIL vec_b3: got %h expected a78fb5a1", rk_pair);
                end
            end
            if (b == 24) begin
                n_checks++;
                if (rk_pair !== 32'hc73d_6b16 || rk_last !== 1'b1 || rk_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL vec_b24: got %h last=%b v=%b expected c73d6b16 1 1",
                             rk_pair, rk_last, rk_valid);
                end
            end else begin
                n_checks++;
                if (rk_last !== 1'b0 || rk_valid !== 1'b1 || key_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL vec_flags%0d: got last=%b v=%b kr=%b expected 0 1 0",
                             b, rk_last, rk_valid, key_ready);
                end
            end
            @(negedge clk);
        end
        n_checks++;
        if (key_ready !== 1'b1 || rk_valid !== 1'b0 || wk !== 64'h0033_2211_8877_6699) begin
            n_fail++;
            $display("FAIL vec_end: got kr=%b v=%b wk=%h expected 1 0 0033221188776699",
                     key_ready, rk_valid, wk);
        end
`ifdef PICCOLO_RK_BUFFER_EN
        n_checks++;
        if (rk_all[799:768] !== 32'h4349_4f4a || rk_all[31:0] !== 32'hc73d_6b16 ||
            rk_all_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL vec_buf: got %h %h valid=%b expected 43494f4a c73d6b16 1",
                     rk_all[799:768], rk_all[31:0], rk_all_valid);
        end
`endif
    endtask

    task automatic test_stall;
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        send_key(K1);
        while (busy === 1'b1 && cyc < 400) begin
            n_checks++;
            if (rk_valid !== 1'b1 || rk_pair !== exp_rk(K1, acc) ||
                rk_round !== 5'(acc) || rk_last !== (acc == 24)) begin
                n_fail++;
                $display("FAIL stall_beat%0d: got pair=%h rnd=%0d last=%b expected %h",
                         acc, rk_pair, rk_round, rk_last, exp_rk(K1, acc));
            end
            rk_ready = 1'($urandom_range(0, 1));
            if (rk_ready)
                acc++;
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b0;
        n_checks++;
        if (acc !== 25 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_count: got %0d beats busy=%b expected 25 0", acc, busy);
        end
    endtask

    task automatic test_back_to_back;
        key       = K1;
        key_valid = 1'b1;
        @(negedge clk);
        key       = K2;
        rk_ready  = 1'b1;
        for (int b = 0; b < 25; b++) begin
            n_checks++;
            if (key_ready !== 1'b0 || wk !== exp_wk(K1) || rk_pair !== exp_rk(K1, b)) begin
                n_fail++;
                $display("FAIL hold_beat%0d: got kr=%b wk=%h pair=%h expected 0 %h %h",
                         b, key_ready, wk, rk_pair, exp_wk(K1), exp_rk(K1, b));
            end
            @(negedge clk);
        end
        n_checks++;
        if (key_ready !== 1'b1 || wk !== exp_wk(K1)) begin
            n_fail++;
            $display("FAIL hold_idle: got kr=%b wk=%h expected 1 %h", key_ready, wk, exp_wk(K1));
        end
        @(negedge clk);
        key_valid = 1'b0;
        drain_full(K2, "second");
    endtask

    task automatic test_reset_mid;
        send_key(K2);
        rk_ready = 1'b1;
        for (int b = 0; b < 10; b++)
            @(negedge clk);
        n_checks++;
        if (rk_round !== 5'd10 || rk_pair !== exp_rk(K2, 10)) begin
            n_fail++;
            $display("FAIL mid_beat10: got rnd=%0d pair=%h expected 10 %h",
                     rk_round, rk_pair, exp_rk(K2, 10));
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (rk_valid !== 1'b0 || rk_pair !== 32'h0 || rk_round !== 5'd0 ||
            rk_last !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 ||
            wk !== 64'h0 || wk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got v=%b pair=%h rnd=%0d last=%b busy=%b kr=%b wk=%h wkv=%b expected zeros kr=1",
                     rk_valid, rk_pair, rk_round, rk_last, busy, key_ready, wk, wk_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || rk_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release: got busy=%b v=%b expected 0 0", busy, rk_valid);
        end
        send_key(K1);
        drain_full(K1, "after_reset");
    endtask

    initial begin
        test_reset;
        test_vectors;
        test_stall;
        test_back_to_back;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/piccolo_key_sched_seq.md
# piccolo_key_sched_seq

Sequential Piccolo-80 key schedule. It accepts an 80-bit key over a valid/ready handshake and registers the four 16-bit whitening keys. It then streams the 25 round-key pairs (rk(2i), rk(2i+1)) one pair per accepted beat to a round-iterative Piccolo datapath downstream. It replaces the fully unrolled combinational schedule wherever the 800-bit round-key bus is too costly.

## Interface
Parameters: none; block size 64 bits, key 80 bits, 25 rounds are fixed.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- key_valid  in  1  key offered
- key_ready  out  1  block can accept a key
- key  in  80  cipher key K; k0 = K[79:64] … k4 = K[15:0]
- wk  out  64  {wk0,wk1,wk2,wk3}, wk0 in [63:48]
- wk_valid  out  1  wk holds keys of the most recently accepted K
- rk_pair  out  32  {rk(2i), rk(2i+1)}, rk(2i) in [31:16]
- rk_round  out  5  round index i, 0..24
- rk_last  out  1  asserted with the rk_valid beat where i = 24
- rk_valid  out  1  rk_pair is valid
- rk_ready  in  1  consumer accepts the current pair
- busy  out  1  streaming in progress (state RUN)

## Operation
- FSM states: IDLE and RUN.
- IDLE:
  - key_ready = 1, rk_valid = 0.
  - On key_valid, capture key into k0..k4 and register wk. Next cycle: RUN, i = 0, i mod 5 = 0.
- Whitening keys (H = upper byte, L = lower byte):
  - wk0 = {k0H, k1L}
  - wk1 = {k1H, k0L}
  - wk2 = {k4H, k3L}
  - wk3 = {k3H, k4L}
- Round constant for round i, 32 bits:
  - con = {c, 5'b0, c, 2'b00, c, 5'b0, c} XOR 32'h0f1e2d3c, with c = i+1 as 5 bits.
- Key selection by i mod 5:
  - 0 or 2 → {k2, k3}
  - 1 or 4 → {k0, k1}
  - 3 → {k4, k4}
- rk_pair = selected key XOR con.
- Track i mod 5 with a separate wrapping 3-bit counter; no divider.
- RUN:
  - rk_valid = 1, key_ready = 0, key is ignored.
  - On rk_valid & rk_ready, i increments.
  - When the i = 24 beat is accepted, return to IDLE.
- rk_valid stalls while rk_ready = 0. rk_pair, rk_round and rk_last stay stable until accepted.
- wk and wk_valid stay unchanged through RUN and IDLE until the next key is accepted. A new key replaces wk in the capture cycle.

## Timing
- Reset values (async, immediate):
  - state = IDLE, key_ready = 1.
  - wk = 0, wk_valid = 0.
  - rk_pair = 0, rk_round = 0, rk_last = 0, rk_valid = 0, busy = 0.
  - Internal k0..k4 = 0.
- Key accepted at edge T: wk/wk_valid valid after T; first rk_valid after T.
- With rk_ready held high: 25 beats on consecutive cycles (T+1..T+25); key_ready is high again from the cycle after the last beat.
  - Minimum key-to-key spacing is 26 cycles.
- rk_pair is combinational from registered k, i and mod-5 counter. There are no combinational paths from any input to any output.
- Reset asserted mid-RUN aborts the stream immediately. No partial rk_last is emitted; after release the block is in IDLE.
- key_valid asserted during RUN is held off (key_ready = 0); the block does not drop or buffer it.

## Configuration
- PICCOLO_RK_BUFFER_EN defined:
  - Adds outputs rk_all [799:0] and rk_all_valid.
  - Each accepted beat writes rk(2i) to rk_all[799-32i -: 16] and rk(2i+1) to rk_all[783-32i -: 16].
  - rk_all_valid rises the cycle after the i = 24 beat. It clears on reset or on the next key capture.
  - rk_all resets to 0.
- Undefined: the ports and the 800-bit register are absent; streaming behaviour is identical.

## Test plan
- Key 80'h00112233445566778899 with rk_ready = 1 → the following values:
  - wk = 64'h0033_2211_8877_6699.
  - Beat 0 rk_pair = 32'h4349_4f4a, beat 1 = 32'h1f0b_070d, beat 3 = 32'ha78f_b5a1.
  - Beat 24 = 32'hc73d_6b16 with rk_last = 1.
  - key_ready high one cycle later.
- Same key with rk_ready toggling pseudo-randomly → the same 25 pairs in order, each held stable while stalled, exactly 25 accepted beats.
- key_valid held high during RUN with a different key → key_ready = 0 and wk unchanged until stream end; the second key is accepted in the first IDLE cycle.
- rst_n pulsed low at beat 10 → all outputs 0 asynchronously; a subsequent key produces a full, correct 25-beat stream.
- PICCOLO_RK_BUFFER_EN defined, key 80'h00112233445566778899 → rk_all[799:768] = 32'h4349_4f4a, rk_all[31:0] = 32'hc73d_6b16, rk_all_valid high after the last beat.
- Feed wk/rk into the iterative Piccolo datapath with plaintext 64'h0123456789abcdef → ciphertext 64'h8d2bff9935f84056.
